// File: rtl/if_stage_pkg.sv
// Processor-wide constants and the fetch FSM state encoding shared by the fetch stage.
package if_stage_pkg;
    localparam int              DEF_DATA_WIDTH = 16;
    localparam int              DEF_ADDR_WIDTH = 8;
    localparam logic [15:0]     DEF_NOP_INSTR  = 16'h0000;
    localparam logic [7:0]      DEF_RESET_PC   = 8'h00;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset beats hold, hold beats bubble, bubble beats load.
module if_id_reg import if_stage_pkg::*; #(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DEF_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  bubble,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  valid
);
    always_ff @(posedge clk) begin
        if (rst || (!hold && bubble)) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC selection and RUN/HALT FSM feeding the IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch and bubble counters.
module if_stage import if_stage_pkg::*; #(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DEF_NOP_INSTR,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    input  logic [DATA_WIDTH-1:0] im_rdata_i,
    input  logic                  stall_IF_ID_i,
    input  logic                  flush_IF_ID_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  stop_i,
    output logic [ADDR_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] instrD_o,
    output logic                  validD_o,
    output logic                  halted_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]           fetch_cnt_o,
    output logic [15:0]           bubble_cnt_o
`endif
);
    fetch_state_e          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_inc;
    logic                  hold, bubble, advance;

    assign im_addr_o = pc;
    assign pc_inc    = ADDR_WIDTH'(pc + 1'b1);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        hold       = 1'b0;
        bubble     = 1'b0;
        advance    = 1'b0;
        if (state == S_HALT) begin
            bubble = 1'b1;
        end else if (branch_taken_i) begin
            // Both the ID and IF instructions are wrong-path, so this outranks stall.
            pc_next = branch_target_i;
            bubble  = 1'b1;
        end else if (stall_IF_ID_i) begin
            hold = 1'b1;
        end else if (stop_i) begin
            state_next = S_HALT;
            bubble     = 1'b1;
        end else if (jump_i) begin
            pc_next = jumpAddr_i;
            bubble  = 1'b1;
        end else if (flush_IF_ID_i) begin
            pc_next = pc_inc;
            bubble  = 1'b1;
        end else begin
            pc_next = pc_inc;
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            pc       <= RESET_PC;
            halted_o <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            halted_o <= (state_next == S_HALT);
        end
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .bubble   (bubble),
        .pc_in    (pc),
        .instr_in (im_rdata_i),
        .pc       (PCD_o),
        .instr    (instrD_o),
        .valid    (validD_o)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (advance && fetch_cnt_o != 16'hFFFF)
                fetch_cnt_o <= fetch_cnt_o + 16'd1;
            if (state == S_RUN && bubble && bubble_cnt_o != 16'hFFFF)
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expected values are hand-computed per scenario.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  im_addr;
    logic [15:0] im_rdata;
    logic        stall, flush, jump, branch, stop;
    logic [7:0]  jump_addr, branch_tgt;
    logic [7:0]  pcd;
    logic [15:0] instrd;
    logic        valid, halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt, bubble_cnt;
    logic [15:0] bub_before;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [33:0] exp_v;

    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address.
    assign im_rdata = 16'h1000 + {8'h00, im_addr};

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .im_addr_o       (im_addr),
        .im_rdata_i      (im_rdata),
        .stall_IF_ID_i   (stall),
        .flush_IF_ID_i   (flush),
        .jump_i          (jump),
        .jumpAddr_i      (jump_addr),
        .branch_taken_i  (branch),
        .branch_target_i (branch_tgt),
        .stop_i          (stop),
        .PCD_o           (pcd),
        .instrD_o        (instrd),
        .validD_o        (valid),
        .halted_o        (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt),
        .bubble_cnt_o    (bubble_cnt)
`endif
    );

    function automatic logic [33:0] snap();
        return {im_addr, pcd, instrd, valid, halted};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; jump = 0; branch = 0; stop = 0;
        jump_addr = 8'h00; branch_tgt = 8'h00;
    endtask

    // Redirect to a known PC via a taken branch; IF/ID holds a bubble afterwards.
    task automatic goto_pc(input logic [7:0] a);
        idle(); branch = 1; branch_tgt = a; step(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); step(); rst = 0;
        n_total++;
        if (snap() !== {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_state got %h required %h", snap(), {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_total++;
        if ({fetch_cnt, bubble_cnt} !== 32'h0)
            $display("FAIL reset_counters got %h required 0", {fetch_cnt, bubble_cnt});
        else n_pass++;
`endif
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_v = {8'(k), 8'(k - 1), 16'h1000 + 16'(k - 1), 1'b1, 1'b0};
            n_total++;
            if (snap() !== exp_v) $display("FAIL seq_cycle%0d got %h required %h", k, snap(), exp_v);
            else n_pass++;
        end
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (fetch_cnt !== 16'd4) $display("FAIL fetch_cnt got %0d required 4", fetch_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        goto_pc(8'hFE);
        for (int k = 0; k < 3; k++) begin
            step();
            a = 8'(8'hFE + k);
            exp_v = {8'(a + 8'd1), a, 16'h1000 + {8'h00, a}, 1'b1, 1'b0};
            n_total++;
            if (snap() !== exp_v) $display("FAIL wrap_cycle%0d got %h required %h", k, snap(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        goto_pc(8'h10);
        jump = 1; jump_addr = 8'h40; step(); idle();
        n_total++;
        if (snap() !== {8'h40, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL jump_bubble got %h required %h", snap(), {8'h40, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
        step();
        n_total++;
        if (snap() !== {8'h41, 8'h40, 16'h1040, 1'b1, 1'b0})
            $display("FAIL jump_resume got %h required %h", snap(), {8'h41, 8'h40, 16'h1040, 1'b1, 1'b0});
        else n_pass++;
        goto_pc(8'h10);
        jump = 1; jump_addr = 8'h40; branch = 1; branch_tgt = 8'h80; step(); idle();
        n_total++;
        if (snap() !== {8'h80, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL branch_over_jump got %h required %h", snap(), {8'h80, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_flush();
        goto_pc(8'h60); step();
        flush = 1; step(); idle();
        n_total++;
        if (snap() !== {8'h62, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL flush_only got %h required %h", snap(), {8'h62, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
        flush = 1; jump = 1; jump_addr = 8'h70; step(); idle();
        n_total++;
        if (snap() !== {8'h70, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL flush_jump got %h required %h", snap(), {8'h70, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_stall();
        goto_pc(8'h1F); step();
        stall = 1; jump = 1; jump_addr = 8'h99; stop = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (snap() !== {8'h20, 8'h1F, 16'h101F, 1'b1, 1'b0})
                $display("FAIL stall_hold%0d got %h required %h", k, snap(), {8'h20, 8'h1F, 16'h101F, 1'b1, 1'b0});
            else n_pass++;
        end
        idle(); step();
        n_total++;
        if (snap() !== {8'h21, 8'h20, 16'h1020, 1'b1, 1'b0})
            $display("FAIL stall_release got %h required %h", snap(), {8'h21, 8'h20, 16'h1020, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_stop();
        goto_pc(8'h30);
        stop = 1; jump = 1; jump_addr = 8'h44; step(); idle();
        n_total++;
        if (snap() !== {8'h30, 8'h00, 16'h0000, 1'b0, 1'b1})
            $display("FAIL stop_halt got %h required %h", snap(), {8'h30, 8'h00, 16'h0000, 1'b0, 1'b1});
        else n_pass++;
        jump = 1; jump_addr = 8'h44; branch = 1; branch_tgt = 8'h66;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (snap() !== {8'h30, 8'h00, 16'h0000, 1'b0, 1'b1})
                $display("FAIL halt_ignore%0d got %h required %h", k, snap(), {8'h30, 8'h00, 16'h0000, 1'b0, 1'b1});
            else n_pass++;
        end
        rst = 1; step(); rst = 0; idle();
        n_total++;
        if (snap() !== {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL halt_reset got %h required %h", snap(), {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_stop_branch();
        goto_pc(8'h50); step();
`ifdef IF_PERF_CNT_EN
        bub_before = bubble_cnt;
`endif
        stop = 1; branch = 1; branch_tgt = 8'h55; step(); idle();
        n_total++;
        if (snap() !== {8'h55, 8'h00, 16'h0000, 1'b0, 1'b0})
            $display("FAIL stop_vs_branch got %h required %h", snap(), {8'h55, 8'h00, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
        step();
        n_total++;
        if (halted !== 1'b0) $display("FAIL stop_vs_branch_nohalt got %b required 0", halted);
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (bubble_cnt !== bub_before + 16'd1)
            $display("FAIL bubble_cnt got %0d required %0d", bubble_cnt, bub_before + 16'd1);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_jump();
        test_flush();
        test_stall();
        test_stop();
        test_stop_branch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor.
- Holds the PC and drives the instruction-memory address. Captures the fetched word and its PC into the IF/ID pipeline register, which feeds the decode stage.
- Resolves PC redirects (EX branch, ID jump), hazard-unit stall/flush, and the STOP halt.

Parameters:
- DATA_WIDTH, 16, instruction width
- ADDR_WIDTH, 8, PC / instruction-memory word-address width
- NOP_INSTR, 16'h0000, bubble word loaded into IF/ID on flush, redirect, or halt
- RESET_PC, 8'h00, PC value after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- im_addr_o  out  ADDR_WIDTH  instruction-memory address; equals PC
- im_rdata_i  in  DATA_WIDTH  instruction-memory read data; combinational, same cycle
- stall_IF_ID_i  in  1  hazard unit: hold PC and IF/ID
- flush_IF_ID_i  in  1  hazard unit: load bubble into IF/ID
- jump_i  in  1  decode has a jump
- jumpAddr_i  in  ADDR_WIDTH  jump target from decode
- branch_taken_i  in  1  EX resolved a taken branch
- branch_target_i  in  ADDR_WIDTH  branch target from EX
- stop_i  in  1  decode holds a STOP instruction
- PCD_o  out  ADDR_WIDTH  IF/ID register: PC of the held instruction
- instrD_o  out  DATA_WIDTH  IF/ID register: instruction word
- validD_o  out  1  IF/ID register: 1 = real instruction, 0 = bubble
- halted_o  out  1  fetch is in HALT

Behaviour:
- Reset (rst=1 at posedge) overrides everything and applies at any point, including mid-redirect or in HALT:
  - PC<=RESET_PC, PCD_o<=0, instrD_o<=NOP_INSTR, validD_o<=0
  - state<=S_RUN, halted_o=0
- im_addr_o = PC, combinational. The IF/ID register captures {PC, im_rdata_i, 1} on normal advance, giving 1-cycle fetch latency.
- FSM:
  - S_RUN: normal fetch.
  - S_HALT: PC frozen; IF/ID loads NOP_INSTR with validD_o=0 every cycle; halted_o=1. Only rst leaves S_HALT.
- S_RUN per-cycle priority, highest first:
  - 1) branch_taken_i: PC<=branch_target_i; IF/ID<=bubble. Overrides stall, jump and stop, because the ID and IF instructions are wrong-path.
  - 2) stall_IF_ID_i: PC and IF/ID hold. Jump and stop are not acted on; decode re-asserts them while stalled.
  - 3) stop_i: state<=S_HALT; PC holds; IF/ID<=bubble.
  - 4) jump_i: PC<=jumpAddr_i; IF/ID<=bubble. One-cycle jump penalty.
  - 5) flush_IF_ID_i: IF/ID<=bubble; PC<=PC+1.
  - 6) normal: IF/ID<={PC, im_rdata_i, 1}; PC<=PC+1.
- PC arithmetic: unsigned ADDR_WIDTH, word addressed, increments by 1 and wraps 8'hFF -> 8'h00 with no error. Redirect targets are taken verbatim.
- Simultaneous jump_i and stop_i: stop wins (stop-first).
- Simultaneous flush_IF_ID_i and jump_i: both produce a bubble; jump target is used.
- A bubble always carries PCD_o=0, instrD_o=NOP_INSTR, validD_o=0.
- halted_o is registered; it asserts the cycle after the STOP is accepted.

Optional Feature:
- Macro: IF_PERF_CNT_EN
- Defined:
  - Adds output fetch_cnt_o [15:0]: increments on every normal advance (priority 6), saturates at 16'hFFFF, reset to 0.
  - Adds output bubble_cnt_o [15:0]: increments on every cycle that loads a bubble in S_RUN; same saturation and reset.
- Undefined: neither port nor counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package (processor-wide):
  - ADDR_WIDTH/DATA_WIDTH defaults
  - NOP_INSTR
  - RESET_PC
  - FSM state encoding localparams S_RUN=1'b0, S_HALT=1'b1
- Sub-module if_id_reg: the IF/ID register with hold / bubble / load controls. This keeps if_stage to PC and next-PC selection plus the FSM.

Test Plan:
- Reset then 5 free-running cycles, im_rdata_i=16'h1000+addr -> im_addr_o 0..4; PCD_o/instrD_o lag by one cycle (PCD_o=3, instrD_o=16'h1003 in cycle 4); validD_o=1 from cycle 1.
- PC=8'hFE, no redirects, 3 cycles -> im_addr_o FE, FF, 00 (wrap); instrD_o follows with no bubble.
- PC=8'h10: jump_i=1, jumpAddr_i=8'h40 -> next im_addr_o=40, IF/ID bubble for 1 cycle. Same cycle plus branch_taken_i=1, branch_target_i=8'h80 -> im_addr_o=80 (branch wins).
- stall_IF_ID_i=1 for 3 cycles at PC=8'h20 -> im_addr_o, PCD_o, instrD_o unchanged. After release -> PC=21 and IF/ID loads PC 20's word.
- stop_i=1 at PC=8'h30 -> next cycle halted_o=1, im_addr_o stays 30, validD_o=0 indefinitely; jump_i/branch_taken_i ignored. rst -> PC=0, halted_o=0.
- stop_i and branch_taken_i (target 8'h55) together -> no halt, im_addr_o=55. With IF_PERF_CNT_EN: bubble_cnt_o increments by 1.
